// File: rtl/xadac_obi_arb.sv
// xadac_obi_arb: N-to-1 OBI request arbiter with in-order response routing.
//
// One xadac OBI slave port is shared by NumMst masters. A request that is
// offered to the slave but not granted is locked to its master until the
// grant arrives. This keeps the slave-side request fields stable. Every
// granted master index is pushed into an in-order FIFO. Responses are
// steered to the master at the FIFO head.
//
// Build option: define XADAC_OBI_ARB_RR_EN for round-robin arbitration.
// When it is left undefined, the lowest requesting index wins and there
// is no round-robin pointer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | arbitrate among requesters each cycle
// ST_LOCKED | request offered but not yet granted; hold the locked master
module xadac_obi_arb #(
  parameter int unsigned NumMst    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned MaxTrans  = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumMst-1:0]               mst_req_i,
  output logic [NumMst-1:0]               mst_gnt_o,
  input  logic [NumMst*AddrWidth-1:0]     mst_addr_i,
  input  logic [NumMst-1:0]               mst_we_i,
  input  logic [NumMst*DataWidth/8-1:0]   mst_be_i,
  input  logic [NumMst*DataWidth-1:0]     mst_wdata_i,
  input  logic [NumMst*IdWidth-1:0]       mst_aid_i,
  output logic [NumMst-1:0]               mst_rvalid_o,
  input  logic [NumMst-1:0]               mst_rready_i,
  output logic [DataWidth-1:0]            mst_rdata_o,
  output logic [IdWidth-1:0]              mst_rid_o,
  output logic                            slv_req_o,
  input  logic                            slv_gnt_i,
  output logic [AddrWidth-1:0]            slv_addr_o,
  output logic                            slv_we_o,
  output logic [DataWidth/8-1:0]          slv_be_o,
  output logic [DataWidth-1:0]            slv_wdata_o,
  output logic [IdWidth-1:0]              slv_aid_o,
  input  logic                            slv_rvalid_i,
  output logic                            slv_rready_o,
  input  logic [DataWidth-1:0]            slv_rdata_i,
  input  logic [IdWidth-1:0]              slv_rid_i
);

  localparam int unsigned IdxW = (NumMst > 1) ? $clog2(NumMst) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans) + 1;
  localparam int unsigned BeW  = DataWidth / 8;

  localparam logic [PtrW-1:0] PTR_LAST = PtrW'(MaxTrans - 1);
  localparam logic [CntW-1:0] CNT_MAX  = CntW'(MaxTrans);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      r_state;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_fifo [MaxTrans];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic [IdxW-1:0] w_arb_idx;
  logic [IdxW-1:0] w_sel;
  logic [IdxW-1:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_hs;
  logic            w_pop;

  assign w_full  = (r_count == CNT_MAX);
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

`ifdef XADAC_OBI_ARB_RR_EN
  localparam logic [IdxW-1:0] IDX_LAST = IdxW'(NumMst - 1);

  logic [IdxW-1:0] r_rr_ptr;
  logic [IdxW-1:0] w_rr_cand;
  logic            w_arb_hit;

  // Round-robin pick: the first requester at or after the pointer, wrapping.
  always_comb begin
    w_arb_idx = '0;
    w_arb_hit = 1'b0;
    w_rr_cand = '0;
    for (int i = 0; i < int'(NumMst); i++) begin
      w_rr_cand = IdxW'((int'(r_rr_ptr) + i) % int'(NumMst));
      if (!w_arb_hit && mst_req_i[w_rr_cand]) begin
        w_arb_hit = 1'b1;
        w_arb_idx = w_rr_cand;
      end
    end
  end

  // Pointer moves just past the master that completed a handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (w_sel == IDX_LAST) ? '0 : w_sel + 1'b1;
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    w_arb_idx = '0;
    for (int i = int'(NumMst) - 1; i >= 0; i--) begin
      if (mst_req_i[i]) w_arb_idx = IdxW'(i);
    end
  end
`endif

  // While reset is asserted the request side is forced quiet and the
  // select is parked on index 0. Once a request is locked it stays offered,
  // even if the master misbehaves and drops req.
  always_comb begin
    w_sel = '0;
    if (rst_ni) w_sel = (r_state == ST_LOCKED) ? r_lock_idx : w_arb_idx;
  end

  assign slv_req_o = rst_ni & ~w_full & ((r_state == ST_LOCKED) | (|mst_req_i));
  assign w_hs      = slv_req_o & slv_gnt_i;

  assign slv_addr_o  = mst_addr_i[w_sel*AddrWidth +: AddrWidth];
  assign slv_we_o    = mst_we_i[w_sel];
  assign slv_be_o    = mst_be_i[w_sel*BeW +: BeW];
  assign slv_wdata_o = mst_wdata_i[w_sel*DataWidth +: DataWidth];
  assign slv_aid_o   = mst_aid_i[w_sel*IdWidth +: IdWidth];

  // The grant is steered to the selected master only.
  always_comb begin
    mst_gnt_o        = '0;
    mst_gnt_o[w_sel] = w_hs;
  end

  // Responses go to the oldest outstanding master. With nothing outstanding
  // the response is left unacknowledged.
  always_comb begin
    mst_rvalid_o         = '0;
    mst_rvalid_o[w_head] = slv_rvalid_i & ~w_empty;
  end

  assign slv_rready_o = mst_rready_i[w_head] & ~w_empty;
  assign w_pop        = slv_rvalid_i & slv_rready_o;
  assign mst_rdata_o  = slv_rdata_i;
  assign mst_rid_o    = slv_rid_i;

  // Lock FSM: an offered but ungranted request pins the select until granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_lock_idx <= '0;
    end else if (r_state == ST_IDLE) begin
      if (slv_req_o && !slv_gnt_i) begin
        r_state    <= ST_LOCKED;
        r_lock_idx <= w_sel;
      end
    end else if (slv_gnt_i) begin
      r_state <= ST_IDLE;
    end
  end

  // In-order FIFO of granted master indices. It is pushed on a handshake
  // and popped on an accepted response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxTrans); i++) r_fifo[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_hs) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      end
      if (w_hs && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_hs && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xadac_obi_arb.sv
// Directed bench for xadac_obi_arb. The expected grant order follows
// XADAC_OBI_ARB_RR_EN.
module tb_xadac_obi_arb;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MT = 4;
`ifdef XADAC_OBI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic [NM-1:0]      mst_req_i;
  logic [NM-1:0]      mst_gnt_o;
  logic [NM*AW-1:0]   mst_addr_i;
  logic [NM-1:0]      mst_we_i;
  logic [NM*DW/8-1:0] mst_be_i;
  logic [NM*DW-1:0]   mst_wdata_i;
  logic [NM*IW-1:0]   mst_aid_i;
  logic [NM-1:0]      mst_rvalid_o;
  logic [NM-1:0]      mst_rready_i;
  logic [DW-1:0]      mst_rdata_o;
  logic [IW-1:0]      mst_rid_o;
  logic               slv_req_o;
  logic               slv_gnt_i;
  logic [AW-1:0]      slv_addr_o;
  logic               slv_we_o;
  logic [DW/8-1:0]    slv_be_o;
  logic [DW-1:0]      slv_wdata_o;
  logic [IW-1:0]      slv_aid_o;
  logic               slv_rvalid_i;
  logic               slv_rready_o;
  logic [DW-1:0]      slv_rdata_i;
  logic [IW-1:0]      slv_rid_i;

  xadac_obi_arb #(
    .NumMst(NM), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxTrans(MT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mst_req_i(mst_req_i), .mst_gnt_o(mst_gnt_o), .mst_addr_i(mst_addr_i),
    .mst_we_i(mst_we_i), .mst_be_i(mst_be_i), .mst_wdata_i(mst_wdata_i),
    .mst_aid_i(mst_aid_i), .mst_rvalid_o(mst_rvalid_o), .mst_rready_i(mst_rready_i),
    .mst_rdata_o(mst_rdata_o), .mst_rid_o(mst_rid_o),
    .slv_req_o(slv_req_o), .slv_gnt_i(slv_gnt_i), .slv_addr_o(slv_addr_o),
    .slv_we_o(slv_we_o), .slv_be_o(slv_be_o), .slv_wdata_o(slv_wdata_o),
    .slv_aid_o(slv_aid_o), .slv_rvalid_i(slv_rvalid_i), .slv_rready_o(slv_rready_o),
    .slv_rdata_i(slv_rdata_i), .slv_rid_i(slv_rid_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  logic [1:0] eg;
  logic [1:0] route [5];

  initial begin
    mst_req_i    = 2'b11;
    mst_addr_i   = {32'h0000_0200, 32'h0000_0100};
    mst_we_i     = 2'b00;
    mst_be_i     = 8'hFF;
    mst_wdata_i  = {32'h2222_2222, 32'h1111_1111};
    mst_aid_i    = {4'd5, 4'd3};
    mst_rready_i = 2'b11;
    slv_gnt_i    = 1'b1;
    slv_rvalid_i = 1'b0;
    slv_rdata_i  = '0;
    slv_rid_i    = '0;

    // Reset values with requests and a grant pending.
    #2;
    chk("rst_req", slv_req_o, 1'b0);
    chk("rst_gnt", mst_gnt_o, 2'b00);
    chk("rst_rvalid", mst_rvalid_o, 2'b00);
    chk("rst_rready", slv_rready_o, 1'b0);
    smp();
    rst_ni    = 1'b1;
    mst_req_i = 2'b00;
    slv_gnt_i = 1'b0;
    nxt();

    // Back-to-back grants until the FIFO fills.
    for (int i = 0; i < 4; i++) begin
      mst_req_i = 2'b11;
      slv_gnt_i = 1'b1;
      eg = RR ? ((i % 2 == 1) ? 2'b10 : 2'b01) : 2'b01;
      route[i] = (eg == 2'b10) ? 2'd1 : 2'd0;
      smp();
      chk($sformatf("rr_gnt%0d", i), mst_gnt_o, eg);
      chk($sformatf("rr_addr%0d", i), slv_addr_o, (eg == 2'b10) ? 32'h200 : 32'h100);
      nxt();
    end
    // Full: no request even though a pop happens in this same cycle.
    slv_rvalid_i = 1'b1;
    slv_rdata_i  = 32'hA000_0000;
    smp();
    chk("full_req", slv_req_o, 1'b0);
    chk("full_gnt", mst_gnt_o, 2'b00);
    chk("full_pop_rvalid", mst_rvalid_o, 2'b01 << route[0]);
    chk("full_pop_rready", slv_rready_o, 1'b1);
    nxt();
    slv_rvalid_i = 1'b0;
    smp();
    chk("after_pop_req", slv_req_o, 1'b1);
    chk("after_pop_gnt", mst_gnt_o, 2'b01);
    route[4] = 2'd0;
    nxt();

    // Drain the remaining responses in order.
    mst_req_i = 2'b00;
    slv_gnt_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      slv_rvalid_i = 1'b1;
      slv_rdata_i  = 32'hA000_0000 + i;
      slv_rid_i    = 4'(i);
      smp();
      chk($sformatf("route%0d", i), mst_rvalid_o, 2'b01 << route[i]);
      chk($sformatf("rdata%0d", i), mst_rdata_o, 32'hA000_0000 + i);
      chk($sformatf("rid%0d", i), mst_rid_o, 4'(i));
      nxt();
    end
    slv_rvalid_i = 1'b0;
    smp();
    chk("drain_count", dut.r_count, 0);
    nxt();

    // Single master read.
    mst_req_i = 2'b01;
    slv_gnt_i = 1'b1;
    smp();
    chk("single_gnt", mst_gnt_o, 2'b01);
    chk("single_addr", slv_addr_o, 32'h100);
    chk("single_aid", slv_aid_o, 4'd3);
    nxt();
    mst_req_i = 2'b00;
    slv_gnt_i = 1'b0;
    nxt();
    slv_rvalid_i = 1'b1;
    slv_rdata_i  = 32'hDEAD_BEEF;
    slv_rid_i    = 4'd3;
    smp();
    chk("single_rvalid", mst_rvalid_o, 2'b01);
    chk("single_rdata", mst_rdata_o, 32'hDEAD_BEEF);
    chk("single_rid", mst_rid_o, 4'd3);
    nxt();
    slv_rvalid_i = 1'b0;
    smp();
    chk("single_count", dut.r_count, 0);
    nxt();

    // Lock: master 0 is offered and held for three ungranted cycles.
    for (int i = 0; i < 4; i++) begin
      mst_req_i = (i == 0) ? 2'b01 : 2'b11;
      slv_gnt_i = (i == 3);
      smp();
      chk($sformatf("lock_addr%0d", i), slv_addr_o, 32'h100);
      chk($sformatf("lock_gnt%0d", i), mst_gnt_o, (i == 3) ? 2'b01 : 2'b00);
      nxt();
    end
    mst_req_i = 2'b10;
    slv_gnt_i = 1'b1;
    smp();
    chk("lock_next_gnt", mst_gnt_o, 2'b10);
    chk("lock_next_addr", slv_addr_o, 32'h200);
    nxt();

    // Backpressure on master 1's response.
    mst_req_i    = 2'b00;
    slv_gnt_i    = 1'b0;
    slv_rvalid_i = 1'b1;
    smp();
    chk("bp_first_rvalid", mst_rvalid_o, 2'b01);
    nxt();
    mst_rready_i = 2'b01;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk($sformatf("bp_hold_rvalid%0d", i), mst_rvalid_o, 2'b10);
      chk($sformatf("bp_hold_rready%0d", i), slv_rready_o, 1'b0);
      nxt();
    end
    mst_rready_i = 2'b11;
    smp();
    chk("bp_rise_rready", slv_rready_o, 1'b1);
    chk("bp_rise_rvalid", mst_rvalid_o, 2'b10);
    nxt();
    slv_rvalid_i = 1'b0;
    smp();
    chk("bp_count", dut.r_count, 0);
    nxt();

    // Reset mid-operation: two outstanding transactions, then lock.
    mst_req_i = 2'b01;
    slv_gnt_i = 1'b1;
    nxt();
    nxt();
    mst_req_i = 2'b11;
    slv_gnt_i = 1'b0;
    smp();
    chk("mid_req", slv_req_o, 1'b1);
    nxt();
    chk("mid_locked", dut.r_state, 1);
    chk("mid_count", dut.r_count, 2);
    #1;
    rst_ni       = 1'b0;
    slv_gnt_i    = 1'b1;
    slv_rvalid_i = 1'b1;
    #1;
    chk("mid_rst_req", slv_req_o, 1'b0);
    chk("mid_rst_gnt", mst_gnt_o, 2'b00);
    chk("mid_rst_rvalid", mst_rvalid_o, 2'b00);
    chk("mid_rst_rready", slv_rready_o, 1'b0);
    nxt();
    smp();
    rst_ni    = 1'b1;
    mst_req_i = 2'b00;
    slv_gnt_i = 1'b0;
    #1;
    chk("post_rst_count", dut.r_count, 0);
    chk("post_rst_stray_rready", slv_rready_o, 1'b0);
    chk("post_rst_stray_rvalid", mst_rvalid_o, 2'b00);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xadac_obi_arb.md
Name: xadac_obi_arb

Overview:
- N-to-1 OBI request arbiter. Shares one xadac OBI slave port, e.g. the memory-side port of the XADAC unit, between NumMst requesters, such as the vector load/store and instruction-fetch agents.
- Responses return in order. They are routed back to the originating master through an internal in-order transaction FIFO of granted master indices.
- Each request is held locked to one master until it is granted, so address and data on the slave side stay stable, as OBI requires.

Parameters:
- NumMst, 2, number of requesting masters (≥2).
- AddrWidth, 32, address width.
- DataWidth, 32, data width (multiple of 8).
- IdWidth, 4, aid/rid width; passed through unchanged.
- MaxTrans, 4, maximum outstanding granted-but-unresponded transactions (power of 2, ≥1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mst_req_i  in  NumMst  per-master request.
- mst_gnt_o  out  NumMst  per-master grant.
- mst_addr_i  in  NumMst*AddrWidth  addresses; master k occupies bits [k*AddrWidth +: AddrWidth].
- mst_we_i  in  NumMst  write enables.
- mst_be_i  in  NumMst*DataWidth/8  byte enables.
- mst_wdata_i  in  NumMst*DataWidth  write data.
- mst_aid_i  in  NumMst*IdWidth  request IDs.
- mst_rvalid_o  out  NumMst  per-master response valid.
- mst_rready_i  in  NumMst  per-master response ready.
- mst_rdata_o  out  DataWidth  response data, broadcast to all masters.
- mst_rid_o  out  IdWidth  response ID, broadcast to all masters.
- slv_req_o  out  1  request to slave.
- slv_gnt_i  in  1  slave grant.
- slv_addr_o  out  AddrWidth  selected master's address.
- slv_we_o  out  1  selected master's write enable.
- slv_be_o  out  DataWidth/8  selected master's byte enables.
- slv_wdata_o  out  DataWidth  selected master's write data.
- slv_aid_o  out  IdWidth  selected master's request ID.
- slv_rvalid_i  in  1  slave response valid.
- slv_rready_o  out  1  slave response ready.
- slv_rdata_i  in  DataWidth  slave response data.
- slv_rid_i  in  IdWidth  slave response ID.

Behaviour:
- Reset (rst_ni low, asynchronous) clears:
  - the RR pointer to 0;
  - the lock flag and locked index;
  - the FIFO, so count is 0.
- Reset output values: all mst_gnt_o = 0, slv_req_o = 0, mst_rvalid_o = 0, slv_rready_o = 0. Data outputs are don't-care, driven from index 0.
- Arbitration FSM has two states.
  - IDLE:
    - Select sel = first requesting master at or after the RR pointer, cyclic.
    - slv_req_o = |mst_req_i & !full.
    - Slave request fields are muxed combinationally from sel; zero added latency.
  - LOCKED:
    - Entered when slv_req_o = 1 and slv_gnt_i = 0.
    - sel is held at the registered locked index regardless of other requests.
    - Stays LOCKED until a slave grant occurs, then returns to IDLE.
- Handshake:
  - A handshake is slv_req_o & slv_gnt_i.
  - mst_gnt_o[sel] = slv_gnt_i & slv_req_o; every other grant bit is 0.
  - On a handshake, push sel into the FIFO and set the RR pointer to (sel+1) mod NumMst.
- Full condition:
  - full = (count == MaxTrans).
  - When full, slv_req_o = 0 even if a pop occurs in the same cycle. Full is never bypassed.
  - Lock is not entered while full.
  - A master deasserting req while LOCKED is a protocol violation; the arbiter keeps driving the locked fields.
- Response routing:
  - head = FIFO head index.
  - mst_rvalid_o[head] = slv_rvalid_i & !empty.
  - slv_rready_o = mst_rready_i[head] & !empty.
  - rdata and rid are passed through.
  - Pop on slv_rvalid_i & slv_rready_o.
  - Simultaneous push and pop leaves count unchanged.
  - slv_rvalid_i while empty: slv_rready_o = 0; the response is held off and not routed.
- Same-cycle response: a response may arrive in the same cycle as its own grant only if the FIFO is non-empty. This is in-order only; the head is the oldest transaction.
- Pointers: the FIFO read and write pointers are clog2(MaxTrans) bits and wrap naturally. The count is clog2(MaxTrans)+1 bits.

Optional Feature:
- Macro: XADAC_OBI_ARB_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined:
  - Fixed priority: the lowest requesting index wins in IDLE.
  - The RR pointer register is removed.
  - Lock, FIFO and routing behaviour are unchanged.

Test Plan:
- Single master: NumMst=2, master 0 issues a read at addr 0x100 with aid 3; slave grants in the same cycle and responds two cycles later with rdata 0xDEADBEEF, rid 3.
  - Required: mst_gnt_o = 01 in the request cycle.
  - Required: mst_rvalid_o = 01 with rdata 0xDEADBEEF; FIFO count returns to 0.
- Round-robin (RR_EN defined): masters 0 and 1 request continuously; slave grants every cycle.
  - Required: grants alternate 01, 10, 01, 10.
  - Required: responses are routed 0, 1, 0, 1.
- Lock: masters 0 and 1 request; slave holds gnt=0 for 3 cycles.
  - Required: slv_addr_o stays at master 0's address for all 4 cycles.
  - Required: master 1 is granted next.
- Full: MaxTrans=4, four grants with no responses.
  - Required: the 5th cycle has slv_req_o = 0.
  - Required: after one response pops, slv_req_o = 1 on the following cycle.
- Backpressure: response for master 1 arrives with mst_rready_i[1] = 0 for 2 cycles.
  - Required: slv_rready_o = 0 during those 2 cycles and rvalid is held on master 1.
  - Required: pop occurs on the cycle ready rises.
- Reset mid-operation: assert rst_ni = 0 asynchronously with 2 outstanding transactions and the arbiter LOCKED.
  - Required: outputs go to reset values immediately.
  - Required: after release, count is 0 and a stray slv_rvalid_i sees slv_rready_o = 0.
